// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM sequencer: register map, timebase widths,
// sequencer states and the per-channel output rule.
package pwm_pkg;

  localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [6:0] ADDR_DUTY      = 7'h04;

  localparam int STEP_W = 8;
  localparam logic [STEP_W-1:0] DUTY_FULL = 8'hFF;
  localparam logic [STEP_W-1:0] STEP_LAST = 8'hFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    COMMIT = 2'd2
  } pwm_state_e;

  // Full-duty code means 100% on, so the last step of the period is not dropped.
  function automatic logic chan_level(input logic en_o, input logic en_p,
                                      input logic [STEP_W-1:0] step,
                                      input logic [STEP_W-1:0] duty);
    return en_o & (~en_p | (duty == DUTY_FULL) | (step < duty));
  endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Divides clk down to one tick per PWM step; clr holds the count at zero.
module pwm_prescaler #(
  parameter int unsigned PRESCALE = 13
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || (cnt == CNT_LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick = ~clr & (cnt == CNT_LAST);

endmodule

// File: rtl/pwm_sequencer.sv
// 16-channel PWM output stage: shadow register file written over valid/ready,
// copied to the active set only at a period boundary or on force_update.
module pwm_sequencer
  import pwm_pkg::*;
#(
  parameter int unsigned PRESCALE = 13,
  parameter int          NUM_CH   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [6:0]        wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              force_update,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              frame_start,
  output logic              pending,
  output logic              bad_addr,
  output pwm_state_e        dbg_state
);

  // Handshake: a write transfers on a rising clk edge where wr_valid && wr_ready;
  // the requester must hold wr_addr/wr_data/wr_valid stable until then.
  // wr_ready is low only during the single COMMIT cycle.

  logic [NUM_CH-1:0] sh_en_out, sh_en_pwm, act_en_out, act_en_pwm;
  logic [STEP_W-1:0] sh_duty, act_duty, step;
  pwm_state_e        state;
  logic              tick, wr_fire, addr_ok, wrap;

  pwm_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (state != RUN),
    .tick (tick)
  );

  assign wr_fire   = wr_valid & wr_ready;
  assign addr_ok   = (wr_addr <= ADDR_DUTY);
  assign wrap      = tick & (step == STEP_LAST);
  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_en_out   <= '0;
      sh_en_pwm   <= '0;
      sh_duty     <= '0;
      act_en_out  <= '0;
      act_en_pwm  <= '0;
      act_duty    <= '0;
      step        <= '0;
      pwm_out     <= '0;
      frame_start <= 1'b0;
      pending     <= 1'b0;
      bad_addr    <= 1'b0;
      wr_ready    <= 1'b1;
      state       <= IDLE;
    end else begin
      frame_start <= 1'b0;
      bad_addr    <= wr_fire & ~addr_ok;

      // A write on the COMMIT entry edge lands in the shadow set before the copy.
      if (wr_fire && addr_ok) begin
        pending <= 1'b1;
        case (wr_addr)
          ADDR_EN_OUT_LO: sh_en_out[7:0]  <= wr_data;
          ADDR_EN_OUT_HI: sh_en_out[15:8] <= wr_data;
          ADDR_EN_PWM_LO: sh_en_pwm[7:0]  <= wr_data;
          ADDR_EN_PWM_HI: sh_en_pwm[15:8] <= wr_data;
          ADDR_DUTY:      sh_duty         <= wr_data;
          default: ;
        endcase
      end

      for (int i = 0; i < NUM_CH; i++) begin
        pwm_out[i] <= chan_level(act_en_out[i], act_en_pwm[i], step, act_duty);
      end

      case (state)
        IDLE: begin
          if (force_update || pending) begin
            state    <= COMMIT;
            wr_ready <= 1'b0;
          end
        end
        RUN: begin
          if (force_update || (pending && wrap)) begin
            state    <= COMMIT;
            wr_ready <= 1'b0;
            step     <= '0;
          end else if (tick) begin
            step        <= step + 1'b1;
            frame_start <= wrap;
          end
        end
        COMMIT: begin
          act_en_out <= sh_en_out;
          act_en_pwm <= sh_en_pwm;
          act_duty   <= sh_duty;
          pending    <= 1'b0;
          wr_ready   <= 1'b1;
          step       <= '0;
          if (sh_en_out != '0) begin
            state       <= RUN;
            frame_start <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_sequencer.sv
// Self-checking bench for pwm_sequencer: frame-position reference model with a
// per-cycle compare, directed scenarios with literal expectations, random writes.
module tb_pwm_sequencer;
  import pwm_pkg::*;

  localparam int P     = 13;
  localparam int FRAME = 256 * P;

  logic        clk, rst;
  logic        wr_valid, wr_ready, force_update;
  logic [6:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [15:0] pwm_out;
  logic        frame_start, pending, bad_addr;
  pwm_state_e  dbg_state;

  int checks = 0;
  int errors = 0;
  int printed = 0;

  pwm_sequencer #(.PRESCALE(P), .NUM_CH(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .force_update (force_update),
    .pwm_out      (pwm_out),
    .frame_start  (frame_start),
    .pending      (pending),
    .bad_addr     (bad_addr),
    .dbg_state    (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // mode: 0 idle, 1 running (m_pos = clocks since period start), 2 commit cycle
  int          m_mode, m_pos;
  logic [15:0] ms_eo, ms_ep, ma_eo, ma_ep, m_out;
  logic [7:0]  ms_d, ma_d;
  logic        m_pend, m_frame, m_bad, m_ready;

  function automatic logic [15:0] levels(input logic [15:0] eo, input logic [15:0] ep,
                                         input logic [7:0] d, input int st);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = eo[i] && (!ep[i] || d == 8'hFF || st < int'(d));
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    int   st;
    logic acc, pend_pre;
    if (rst) begin
      m_mode = 0; m_pos = 0;
      ms_eo = '0; ms_ep = '0; ms_d = '0;
      ma_eo = '0; ma_ep = '0; ma_d = '0;
      m_out = '0; m_pend = 0; m_frame = 0; m_bad = 0; m_ready = 1;
    end else begin
      st       = (m_mode == 1) ? m_pos / P : 0;
      m_out    = levels(ma_eo, ma_ep, ma_d, st);
      acc      = wr_valid && m_ready;
      pend_pre = m_pend;
      m_bad    = acc && (wr_addr > 7'd4);
      m_frame  = 0;
      if (acc && wr_addr <= 7'd4) begin
        m_pend = 1;
        case (wr_addr)
          7'd0: ms_eo[7:0]  = wr_data;
          7'd1: ms_eo[15:8] = wr_data;
          7'd2: ms_ep[7:0]  = wr_data;
          7'd3: ms_ep[15:8] = wr_data;
          default: ms_d     = wr_data;
        endcase
      end
      case (m_mode)
        0: if (force_update || pend_pre) m_mode = 2;
        1: begin
          if (force_update || (pend_pre && m_pos == FRAME - 1)) m_mode = 2;
          else if (m_pos == FRAME - 1) begin m_pos = 0; m_frame = 1; end
          else m_pos++;
        end
        default: begin
          ma_eo = ms_eo; ma_ep = ms_ep; ma_d = ms_d;
          m_pend = 0; m_pos = 0;
          if (ms_eo != 16'h0) begin m_mode = 1; m_frame = 1; end
          else m_mode = 0;
        end
      endcase
      m_ready = (m_mode != 2);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if ({pwm_out, frame_start, pending, bad_addr, wr_ready} !==
          {m_out, m_frame, m_pend, m_bad, m_ready}) begin
        errors++;
        if (printed < 30) begin
          printed++;
          $display("FAIL model_cmp t=%0t pwm_out=%h exp=%h fs=%b exp=%b pend=%b exp=%b bad=%b exp=%b rdy=%b exp=%b",
                   $time, pwm_out, m_out, frame_start, m_frame, pending, m_pend,
                   bad_addr, m_bad, wr_ready, m_ready);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic do_write(input logic [6:0] a, input logic [7:0] d);
    int k;
    @(negedge clk);
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    k = 0;
    while (!wr_ready && k < 16) begin @(negedge clk); k++; end
    if (!wr_ready) begin
      checks++; errors++;
      $display("FAIL write_timeout addr=%h actual_ready=0 expected_ready=1", a);
    end
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic force_pulse();
    @(negedge clk); force_update = 1'b1;
    @(negedge clk); force_update = 1'b0;
  endtask

  task automatic wait_frame();
    for (int k = 0; k < 8000; k++) begin
      @(negedge clk);
      if (frame_start) return;
    end
    checks++; errors++;
    $display("FAIL wait_frame timeout actual=no_pulse expected=pulse");
  endtask

  // Called on the negedge where frame_start is seen; returns at the next one.
  task automatic measure(output int len, output int high0, output int others_bad);
    len = 0; high0 = 0; others_bad = 0;
    do begin
      if (pwm_out[0]) high0++;
      if (pwm_out[15:1] != 15'h7FFF) others_bad++;
      len++;
      @(negedge clk);
    end while (!frame_start && len < 8000);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int len, high0, obad, cnt, low_cyc;
    logic [6:0] a;
    rst = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; force_update = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_state", {pwm_out, frame_start, pending, bad_addr, wr_ready, dbg_state},
          {16'h0, 1'b0, 1'b0, 1'b0, 1'b1, IDLE});

    do_write(7'h00, 8'hFF);
    check("pending_set", pending, 1);
    repeat (3) @(negedge clk);
    check("pending_clr", pending, 0);
    check("en_lo_out", pwm_out, 16'h00FF);

    do_write(7'h01, 8'hFF);
    do_write(7'h02, 8'h01);
    do_write(7'h03, 8'h00);
    do_write(7'h04, 8'h40);
    wait_frame();
    wait_frame();
    measure(len, high0, obad);
    check("frame_period", len, FRAME);
    check("ch0_high_40", high0, 64 * P);
    check("others_const1", obad, 0);

    repeat (500) @(negedge clk);
    do_write(7'h04, 8'h80);
    check("pending_mid", pending, 1);
    wait_frame();
    wait_frame();
    measure(len, high0, obad);
    check("ch0_high_80", high0, 128 * P);

    do_write(7'h04, 8'hFF);
    force_pulse();
    wait_frame();
    cnt = 0;
    for (int k = 0; k < 2 * FRAME; k++) begin @(negedge clk); if (!pwm_out[0]) cnt++; end
    check("duty_ff_never_low", cnt, 0);

    do_write(7'h04, 8'h00);
    force_pulse();
    wait_frame();
    cnt = 0;
    for (int k = 0; k < FRAME; k++) begin @(negedge clk); if (pwm_out[0]) cnt++; end
    check("duty_00_never_high", cnt, 0);

    @(negedge clk); force_update = 1'b1;
    @(negedge clk); force_update = 1'b0;
    wr_valid = 1'b1; wr_addr = 7'h02; wr_data = 8'h03;
    low_cyc = 0;
    for (int k = 0; k < 8; k++) begin
      if (wr_ready) break;
      low_cyc++;
      @(negedge clk);
    end
    @(negedge clk); wr_valid = 1'b0;
    check("stall_len", low_cyc, 1);
    check("pending_after_stall", pending, 1);

    do_write(7'h05, 8'hAA);
    check("bad_addr_pulse", bad_addr, 1);
    @(negedge clk);
    check("bad_addr_one_cycle", bad_addr, 0);

    wait_frame();
    repeat (100 * P) @(negedge clk);
    check("pre_rst_active", pwm_out != 16'h0, 1);
    #2 rst = 1'b1;
    #1 check("rst_async_out", pwm_out, 16'h0);
    @(negedge clk); rst = 1'b0;
    repeat (5) @(negedge clk);
    check("post_rst_idle", {pwm_out, pending, dbg_state}, {16'h0, 1'b0, IDLE});
    do_write(7'h01, 8'h0F);
    repeat (3) @(negedge clk);
    check("resume_hi", pwm_out, 16'h0F00);

    for (int it = 0; it < 400; it++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 6) begin
        if ($urandom_range(0, 7) == 0) a = 7'($urandom_range(5, 127));
        else a = 7'($urandom_range(0, 4));
        do_write(a, 8'($urandom));
      end else if (r < 8) begin
        force_pulse();
      end else begin
        repeat ($urandom_range(1, 30)) @(negedge clk);
      end
    end
    repeat (20) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
